iob_eth_rx_filter: RTL and testbench

IOB_ETH_RX_FILTER -- requirements
Module: iob_eth_rx_filter

---
 rtl/iob_eth_rx_filter.sv | 233 +++++++++++++++++++++++
 tb/tb_iob_eth_rx_filter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_filter.sv
// Ethernet RX destination filter: writes accepted frames into the RX buffer and holds them until acknowledged.
// Buffer writes are registered one cycle after the byte; optional multicast acceptance via IOB_ETH_RX_FILTER_MCAST_EN.
module iob_eth_rx_filter #(
    parameter int BUFFER_W = 11,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                en_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_i,
    input  logic                last_i,
    input  logic                crc_err_i,
    input  logic [47:0]         mac_addr_i,
    input  logic                promisc_i,
    input  logic                bcast_en_i,
    output logic                buf_wen_o,
    output logic [BUFFER_W-1:0] buf_addr_o,
    output logic [7:0]          buf_data_o,
    output logic                frame_rdy_o,
    output logic [BUFFER_W:0]   frame_len_o,
    input  logic                rcv_ack_i,
    output logic [CNT_W-1:0]    drop_cnt_o
);

`ifdef IOB_ETH_RX_FILTER_MCAST_EN
    localparam bit MCAST_EN = 1'b1;
`else
    localparam bit MCAST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DADDR, PAYLOAD, DISCARD, PENDING} state_t;

    localparam logic [BUFFER_W-1:0] ADDR_MAX = '1;
    localparam logic [BUFFER_W-1:0] DA_LAST  = BUFFER_W'(5);
    localparam logic [BUFFER_W-1:0] ADDR_ONE = BUFFER_W'(1);
    localparam logic [BUFFER_W:0]   LEN_ONE  = (BUFFER_W + 1)'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic [BUFFER_W-1:0] wr_cnt_q, wr_cnt_d;
    logic                ucast_q, ucast_d;
    logic                bcast_q, bcast_d;
    logic                mcast_q, mcast_d;
    logic                in_frame_q, in_frame_d;
    logic                buf_wen_q, buf_wen_d;
    logic [BUFFER_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]          buf_data_q, buf_data_d;
    logic                frame_rdy_q, frame_rdy_d;
    logic [BUFFER_W:0]   frame_len_q, frame_len_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic       first;
    logic [2:0] byte_idx;
    logic [7:0] mac_byte;
    logic       ucast_now, bcast_now, mcast_now, accept, drop_inc;

    // Byte index within the destination address; IDLE always sees byte 0.
    assign first    = (state_q == IDLE);
    assign byte_idx = first ? 3'd0 : wr_cnt_q[2:0];

    always_comb begin
        case (byte_idx)
            3'd0:    mac_byte = mac_addr_i[47:40];
            3'd1:    mac_byte = mac_addr_i[39:32];
            3'd2:    mac_byte = mac_addr_i[31:24];
            3'd3:    mac_byte = mac_addr_i[23:16];
            3'd4:    mac_byte = mac_addr_i[15:8];
            3'd5:    mac_byte = mac_addr_i[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    assign ucast_now = (first | ucast_q) & (byte_i == mac_byte);
    assign bcast_now = (first | bcast_q) & (byte_i == 8'hFF);
    assign mcast_now = first ? byte_i[0] : mcast_q;
    assign accept    = promisc_i | ucast_now | (bcast_now & bcast_en_i) | (MCAST_EN & mcast_now);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        ucast_d     = ucast_q;
        bcast_d     = bcast_q;
        mcast_d     = mcast_q;
        in_frame_d  = in_frame_q;
        buf_wen_d   = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        frame_rdy_d = frame_rdy_q;
        frame_len_d = frame_len_q;
        drop_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_valid_i) begin
                    if (!en_i) begin
                        state_d = last_i ? IDLE : DISCARD;
                    end else begin
                        buf_wen_d  = 1'b1;
                        buf_addr_d = '0;
                        buf_data_d = byte_i;
                        wr_cnt_d   = ADDR_ONE;
                        ucast_d    = ucast_now;
                        bcast_d    = bcast_now;
                        mcast_d    = mcast_now;
                        if (last_i) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d = DADDR;
                        end
                    end
                end
            end
            DADDR: begin
                if (byte_valid_i) begin
                    buf_wen_d  = 1'b1;
                    buf_addr_d = wr_cnt_q;
                    buf_data_d = byte_i;
                    wr_cnt_d   = wr_cnt_q + ADDR_ONE;
                    ucast_d    = ucast_now;
                    bcast_d    = bcast_now;
                    if (wr_cnt_q == DA_LAST) begin
                        if (!accept) begin
                            drop_inc = 1'b1;
                            state_d  = last_i ? IDLE : DISCARD;
                        end else if (!last_i) begin
                            state_d = PAYLOAD;
                        end else if (crc_err_i) begin
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d     = PENDING;
                            frame_rdy_d = 1'b1;
                            frame_len_d = {1'b0, wr_cnt_q} + LEN_ONE;
                            in_frame_d  = 1'b0;
                        end
                    end else if (last_i) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_valid_i) begin
                    // The last buffer slot is reserved for a final byte; anything longer overflows.
                    if (wr_cnt_q == ADDR_MAX && !last_i) begin
                        drop_inc = 1'b1;
                        state_d  = DISCARD;
                    end else begin
                        buf_wen_d  = 1'b1;
                        buf_addr_d = wr_cnt_q;
                        buf_data_d = byte_i;
                        wr_cnt_d   = wr_cnt_q + ADDR_ONE;
                        if (last_i && crc_err_i) begin
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end else if (last_i) begin
                            state_d     = PENDING;
                            frame_rdy_d = 1'b1;
                            frame_len_d = {1'b0, wr_cnt_q} + LEN_ONE;
                            in_frame_d  = 1'b0;
                        end
                    end
                end
            end
            DISCARD: begin
                if (byte_valid_i && last_i) begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (byte_valid_i && !in_frame_q) begin
                    drop_inc = 1'b1;
                end
                if (rcv_ack_i) begin
                    frame_rdy_d = 1'b0;
                    in_frame_d  = 1'b0;
                    // A frame already under way (or starting now) is not resynced: skip its tail.
                    if ((in_frame_q || byte_valid_i) && !(byte_valid_i && last_i)) begin
                        state_d = DISCARD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (byte_valid_i) begin
                    in_frame_d = !last_i;
                end
            end
            default: state_d = IDLE;
        endcase

        drop_cnt_d = (drop_inc && drop_cnt_q != CNT_MAX) ? drop_cnt_q + CNT_ONE : drop_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            ucast_q     <= 1'b0;
            bcast_q     <= 1'b0;
            mcast_q     <= 1'b0;
            in_frame_q  <= 1'b0;
            buf_wen_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            frame_rdy_q <= 1'b0;
            frame_len_q <= '0;
            drop_cnt_q  <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            ucast_q     <= ucast_d;
            bcast_q     <= bcast_d;
            mcast_q     <= mcast_d;
            in_frame_q  <= in_frame_d;
            buf_wen_q   <= buf_wen_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            frame_rdy_q <= frame_rdy_d;
            frame_len_q <= frame_len_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign buf_wen_o   = buf_wen_q;
    assign buf_addr_o  = buf_addr_q;
    assign buf_data_o  = buf_data_q;
    assign frame_rdy_o = frame_rdy_q;
    assign frame_len_o = frame_len_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_filter.sv
// Bench for iob_eth_rx_filter: a default instance and a small one (6-bit buffer, 3-bit drop counter) share one byte stream.
// A frame-level reference model predicts acceptance, held length, drop count and the buffer writes of each frame.
module tb_iob_eth_rx_filter;
    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    logic        clk_i = 1'b0;
    logic        rst_i, cke_i, en_i, byte_valid_i, last_i, crc_err_i;
    logic [7:0]  byte_i;
    logic [47:0] mac_addr_i;
    logic        promisc_i, bcast_en_i, rcv_ack_i;

    logic        a_wen, a_rdy;
    logic [10:0] a_addr;
    logic [7:0]  a_data;
    logic [11:0] a_len;
    logic [15:0] a_cnt;
    logic        b_wen, b_rdy;
    logic [5:0]  b_addr;
    logic [7:0]  b_data;
    logic [6:0]  b_len;
    logic [2:0]  b_cnt;

    iob_eth_rx_filter dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i), .en_i(en_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .last_i(last_i), .crc_err_i(crc_err_i),
        .mac_addr_i(mac_addr_i), .promisc_i(promisc_i), .bcast_en_i(bcast_en_i),
        .buf_wen_o(a_wen), .buf_addr_o(a_addr), .buf_data_o(a_data),
        .frame_rdy_o(a_rdy), .frame_len_o(a_len), .rcv_ack_i(rcv_ack_i), .drop_cnt_o(a_cnt)
    );

    iob_eth_rx_filter #(.BUFFER_W(6), .CNT_W(3)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i), .en_i(en_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .last_i(last_i), .crc_err_i(crc_err_i),
        .mac_addr_i(mac_addr_i), .promisc_i(promisc_i), .bcast_en_i(bcast_en_i),
        .buf_wen_o(b_wen), .buf_addr_o(b_addr), .buf_data_o(b_data),
        .frame_rdy_o(b_rdy), .frame_len_o(b_len), .rcv_ack_i(rcv_ack_i), .drop_cnt_o(b_cnt)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk  = 0;
    logic [7:0] frm [0:127];
    int m_pend [2];
    int m_plen [2];
    int m_drop [2];
    int m_nw   [2];
    int bw_k   [2] = '{11, 6};
    int cmax_k [2] = '{65535, 7};
    int wq_addr [2][$];
    int wq_data [2][$];
    int stall_at = -1;
    logic cke_prev = 1'b0;

    // Write monitor: a write counts only if the register was loaded at an enabled edge.
    always @(posedge clk_i) cke_prev <= cke_i;
    always @(negedge clk_i) begin
        if (cke_prev) begin
            if (a_wen) begin wq_addr[0].push_back(int'(a_addr)); wq_data[0].push_back(int'(a_data)); end
            if (b_wen) begin wq_addr[1].push_back(int'(b_addr)); wq_data[1].push_back(int'(b_data)); end
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] obs_rdy(input int k);
        return k != 0 ? 64'(b_rdy) : 64'(a_rdy);
    endfunction
    function automatic logic [63:0] obs_len(input int k);
        return k != 0 ? 64'(b_len) : 64'(a_len);
    endfunction
    function automatic logic [63:0] obs_cnt(input int k);
        return k != 0 ? 64'(b_cnt) : 64'(a_cnt);
    endfunction

    task automatic model_drop(input int k);
        if (m_drop[k] < cmax_k[k]) m_drop[k]++;
    endtask

    // Frame-level outcome for each instance, from the filtering rules.
    task automatic model_frame(input int len, input bit crc, input int ack_at);
        logic [47:0] dest;
        bit acc, mc;
        for (int i = 0; i < 6; i++) dest[47-8*i -: 8] = frm[i];
        mc = 1'b0;
`ifdef IOB_ETH_RX_FILTER_MCAST_EN
        mc = dest[40];
`endif
        acc = promisc_i || dest == MAC || (dest == BCAST && bcast_en_i) || mc;
        for (int k = 0; k < 2; k++) begin
            m_nw[k] = 0;
            if (m_pend[k] != 0) begin
                model_drop(k);
                if (ack_at >= 0) m_pend[k] = 0;
            end else if (!en_i) begin
                m_nw[k] = 0;
            end else if (len < 6) begin
                model_drop(k); m_nw[k] = len;
            end else if (!acc) begin
                model_drop(k); m_nw[k] = 6;
            end else if (len > (1 << bw_k[k])) begin
                model_drop(k); m_nw[k] = (1 << bw_k[k]) - 1;
            end else if (crc) begin
                model_drop(k); m_nw[k] = len;
            end else begin
                m_pend[k] = 1; m_plen[k] = len; m_nw[k] = len;
            end
        end
    endtask

    task automatic make_frame(input logic [47:0] d, input int len);
        for (int i = 0; i < len; i++) frm[i] = (i < 6) ? d[47-8*i -: 8] : 8'($urandom());
    endtask

    // trunc > 0 sends only that many bytes with no last marker (used before a reset).
    task automatic send_frame(input int len, input bit crc, input int ack_at, input int trunc);
        int n;
        n = (trunc > 0) ? trunc : len;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                byte_valid_i = 1'b0; last_i = 1'b0; rcv_ack_i = 1'b0;
                tick();
            end
            if (i == stall_at) begin
                cke_i = 1'b0; byte_valid_i = 1'b1; byte_i = 8'($urandom());
                last_i = 1'b1; rcv_ack_i = 1'b1; crc_err_i = 1'b1;
                repeat (3) tick();
                cke_i = 1'b1;
            end
            byte_valid_i = 1'b1;
            byte_i       = frm[i];
            last_i       = (trunc == 0) && (i == len - 1);
            crc_err_i    = last_i ? crc : 1'b0;
            rcv_ack_i    = (i == ack_at);
            tick();
        end
        byte_valid_i = 1'b0; last_i = 1'b0; crc_err_i = 1'b0; rcv_ack_i = 1'b0;
        if (trunc == 0) model_frame(len, crc, ack_at);
    endtask

    task automatic check_all(input string tag);
        string s;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            s = (k != 0) ? {tag, " b"} : {tag, " a"};
            chk({s, " frame_rdy"}, obs_rdy(k), 64'(m_pend[k]));
            if (m_pend[k] != 0) chk({s, " frame_len"}, obs_len(k), 64'(m_plen[k]));
            chk({s, " drop_cnt"}, obs_cnt(k), 64'(m_drop[k]));
            chk({s, " n_writes"}, 64'(wq_addr[k].size()), 64'(m_nw[k]));
            if (wq_addr[k].size() == m_nw[k]) begin
                for (int i = 0; i < m_nw[k]; i++)
                    chk({s, " write addr,data"}, {wq_addr[k][i], wq_data[k][i]}, {i, int'(frm[i])});
            end
            wq_addr[k].delete(); wq_data[k].delete();
            m_nw[k] = 0;
        end
    endtask

    task automatic pulse_ack(input string tag);
        rcv_ack_i = 1'b1;
        tick();
        rcv_ack_i = 1'b0;
        chk({tag, " a rdy after ack"}, 64'(a_rdy), 64'(0));
        chk({tag, " b rdy after ack"}, 64'(b_rdy), 64'(0));
        m_pend[0] = 0; m_pend[1] = 0;
    endtask

    // Reset is applied with the clock enable low to show it still takes effect.
    task automatic do_reset(input string tag);
        rst_i = 1'b1; cke_i = 1'b0;
        byte_valid_i = 1'b0; last_i = 1'b0; rcv_ack_i = 1'b0; crc_err_i = 1'b0;
        tick(); tick();
        chk({tag, " a wen"},  64'(a_wen),  64'(0));
        chk({tag, " a addr"}, 64'(a_addr), 64'(0));
        chk({tag, " a data"}, 64'(a_data), 64'(0));
        chk({tag, " a rdy"},  64'(a_rdy),  64'(0));
        chk({tag, " a len"},  64'(a_len),  64'(0));
        chk({tag, " a cnt"},  64'(a_cnt),  64'(0));
        chk({tag, " b rdy"},  64'(b_rdy),  64'(0));
        chk({tag, " b cnt"},  64'(b_cnt),  64'(0));
        rst_i = 1'b0; cke_i = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            wq_addr[k].delete(); wq_data[k].delete();
            m_pend[k] = 0; m_plen[k] = 0; m_drop[k] = 0; m_nw[k] = 0;
        end
    endtask

    initial begin
        logic [47:0] d;
        int len, ack_at, r;
        bit crc;

        rst_i = 1'b0; cke_i = 1'b1; en_i = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
        last_i = 1'b0; crc_err_i = 1'b0; mac_addr_i = MAC; promisc_i = 1'b0;
        bcast_en_i = 1'b0; rcv_ack_i = 1'b0;
        do_reset("reset");

        // 64-byte unicast frame to the station address.
        make_frame(MAC, 64);
        send_frame(64, 1'b0, -1, 0);
        chk("ucast64 rdy next cycle", 64'(a_rdy), 64'(1));
        check_all("ucast64");
        pulse_ack("ucast64");

        // Broadcast rejected, then accepted.
        do_reset("bcast reset");
        make_frame(BCAST, 50);
        send_frame(50, 1'b0, -1, 0);
        check_all("bcast off");
        bcast_en_i = 1'b1;
        make_frame(BCAST, 40);
        send_frame(40, 1'b0, -1, 0);
        check_all("bcast on");
        pulse_ack("bcast on");
        bcast_en_i = 1'b0;

        // Second frame while one is held.
        do_reset("held reset");
        make_frame(MAC, 30);
        send_frame(30, 1'b0, -1, 0);
        check_all("held first");
        make_frame(MAC, 45);
        send_frame(45, 1'b0, -1, 0);
        check_all("held second");
        pulse_ack("held");

        // Runt, then FCS error.
        do_reset("runt reset");
        make_frame(MAC, 4);
        send_frame(4, 1'b0, -1, 0);
        check_all("runt");
        make_frame(MAC, 60);
        send_frame(60, 1'b1, -1, 0);
        check_all("crc err");

        // 80 bytes: overflows the 64-byte buffer, fits the default one.
        do_reset("ovf reset");
        make_frame(MAC, 80);
        send_frame(80, 1'b0, -1, 0);
        check_all("overflow");
        pulse_ack("overflow");

        do_reset("mcast reset");
        make_frame(MCAST, 50);
        send_frame(50, 1'b0, -1, 0);
        check_all("mcast");
        pulse_ack("mcast");

        // Acknowledge coinciding with the first byte, then mid-frame.
        do_reset("ackfirst reset");
        make_frame(MAC, 20);
        send_frame(20, 1'b0, -1, 0);
        check_all("ackfirst held");
        make_frame(MAC, 25);
        send_frame(25, 1'b0, 0, 0);
        check_all("ackfirst");
        make_frame(MAC, 20);
        send_frame(20, 1'b0, -1, 0);
        check_all("ackmid held");
        make_frame(MAC, 25);
        send_frame(25, 1'b0, 12, 0);
        check_all("ackmid");
        make_frame(MAC, 33);
        send_frame(33, 1'b0, -1, 0);
        check_all("after ackmid");
        pulse_ack("after ackmid");

        en_i = 1'b0;
        make_frame(MAC, 20);
        send_frame(20, 1'b0, -1, 0);
        check_all("disabled");
        en_i = 1'b1;

        // Clock enable low mid-frame with junk inputs must be invisible.
        stall_at = 15;
        make_frame(MAC, 40);
        send_frame(40, 1'b0, -1, 0);
        check_all("cke stall");
        stall_at = -1;
        pulse_ack("cke stall");

        // Reset mid-frame; the tail is evaluated as a fresh frame.
        make_frame(MAC, 30);
        send_frame(30, 1'b0, -1, 10);
        do_reset("midframe reset");
        for (int i = 0; i < 20; i++) frm[i] = frm[i+10];
        send_frame(20, 1'b0, -1, 0);
        check_all("tail frame");
        pulse_ack("tail frame");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            d[47:16] = $urandom();
            d[15:0]  = 16'($urandom());
            if (r == 0) d = MAC;
            else if (r == 1) d = BCAST;
            else if (r == 2) d = MCAST;
            len        = $urandom_range(1, 100);
            crc        = ($urandom_range(0, 7) == 0);
            en_i       = ($urandom_range(0, 7) != 0);
            promisc_i  = ($urandom_range(0, 5) == 0);
            bcast_en_i = 1'($urandom_range(0, 1));
            ack_at     = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            make_frame(d, len);
            send_frame(len, crc, ack_at, 0);
            check_all("random");
            if ($urandom_range(0, 2) == 0) pulse_ack("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
